// File: rtl/stage_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, 2-entry instruction
// FIFO feeding decode, with stall handling and execute-driven PC redirect/squash.
module stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_instruction,
  output logic [31:0] current_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic        squash, squash_nxt;
  logic [1:0]  count, count_nxt;
  logic        rd_ptr, wr_ptr;
  logic        push, pop;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];

  assign instr_valid         = (count != 2'd0);
  assign current_instruction = instr_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign current_pc          = instr_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign imem_req            = (state == REQ);
  assign imem_addr           = fetch_pc;

  // Redirect overrides both ends of the FIFO; squashed responses are never pushed.
  assign push = (state == WAIT) && imem_rvalid && !squash && !redirect_en;
  assign pop  = instr_valid && !stall && !redirect_en;

  always_comb begin
    count_nxt = count;
    if (redirect_en)
      count_nxt = 2'd0;
    else if (push && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !push)
      count_nxt = count - 2'd1;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    squash_nxt   = squash;
    case (state)
      IDLE: begin
        if (redirect_en)
          fetch_pc_nxt = redirect_pc;
        else if (count < 2'd2)
          state_nxt = REQ;
      end
      REQ: begin
        if (redirect_en) begin
          fetch_pc_nxt = redirect_pc;
          if (imem_ready) begin
            state_nxt  = WAIT;
            squash_nxt = 1'b1;
          end
        end else if (imem_ready) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_en) begin
          fetch_pc_nxt = redirect_pc;
          if (imem_rvalid) begin
            squash_nxt = 1'b0;
            state_nxt  = REQ;
          end else begin
            squash_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          squash_nxt = 1'b0;
          state_nxt  = (count_nxt < 2'd2) ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      squash   <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      squash   <= squash_nxt;
      count    <= count_nxt;
      if (redirect_en) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset: the head is masked by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= fetch_pc - 32'd4;
    end
  end

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
Instruction fetch stage, directly upstream of the decode stage.
- Holds the fetch PC and issues one-at-a-time requests to instruction memory.
- Buffers returned instructions in a 2-entry FIFO and presents the head to decode as current_instruction.
- Honours decode's stall and a PC redirect from execute (branch/jump), squashing wrong-path instructions.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000000, word driven on current_instruction when no valid instruction (decode treats 0 as no-op)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  decode cannot accept this cycle; head instruction held and re-presented
redirect_en  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  redirect target, word aligned
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  request byte address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
current_instruction  output  32  FIFO head, or NOP_INSTR when empty
current_pc  output  32  PC of head, 0 when empty
instr_valid  output  1  FIFO non-empty

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous, active-high.
  - Reset values: state IDLE, fetch_pc=RESET_PC, FIFO count=0, squash=0.
  - Output reset values: imem_req=0, imem_addr=RESET_PC, current_instruction=NOP_INSTR, current_pc=0, instr_valid=0.
- Output derivation:
  - All outputs decode from registers only; no combinational path from any input to any output.
  - imem_addr=fetch_pc at all times.
- FSM (3 states):
  - IDLE:
    - imem_req=0.
    - To REQ when count<2 and !redirect_en.
    - On redirect_en: stay in IDLE, load fetch_pc=redirect_pc.
  - REQ:
    - imem_req=1.
    - On imem_ready: fetch_pc+=4, go to WAIT.
    - Hold imem_addr stable until accepted, except on redirect.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid: push {imem_rdata, fetch_pc-4} unless squash=1. Clear squash.
    - After the push, go to REQ if count<2, else IDLE.
    - imem_rvalid is ignored outside WAIT, including stale responses after reset.
- Request admission:
  - At most one outstanding request.
  - A request is only issued when a FIFO slot is free, so a push never overflows.
- Memory latency:
  - Response arrives 1 or more cycles after acceptance.
  - Peak throughput is 1 instruction per 2 cycles.
- Consume: pop the head when instr_valid && !stall && !redirect_en.
- Same cycle push and pop: count unchanged, order preserved.
- Redirect (highest priority, overrides push, pop and stall):
  - FIFO flushed (count=0); the head presented that cycle is dropped and not consumed.
  - fetch_pc=redirect_pc.
  - REQ, not accepted this cycle: go to REQ, re-issuing at redirect_pc next cycle.
  - REQ, accepted this cycle: go to WAIT with squash=1, fetch_pc=redirect_pc.
  - WAIT, no rvalid this cycle: squash=1, stay in WAIT. After the squashed response, go to REQ at redirect_pc.
  - WAIT, rvalid this cycle: response discarded, go to REQ, squash=0.
  - fetch_pc-4 is never used for squashed data.
- FIFO: 2 entries, circular read/write pointers; count ranges 0..2.
- Wrap-around: fetch_pc+4 wraps modulo 2^32.
- Reset mid-operation aborts any request and discards the in-flight response.

Test Plan:
- Reset, imem_ready=1, 1-cycle latency, rdata=addr+0x100, stall=0:
  - imem_req high in the 1st cycle after reset release, addr 0x0.
  - instr_valid after the response edge with instruction 0x100, pc 0.
  - Subsequent instructions 0x104@4, 0x108@8, one every 2 cycles.
- stall held 10 cycles:
  - FIFO fills to 2; imem_req stays 0.
  - Head stays 0x100@0.
  - After release, instructions 0x100, 0x104, 0x108 appear in order, no loss or duplication.
- Redirect to 0x40 while in WAIT:
  - Late response for 0x8 discarded.
  - Next request addr 0x40.
  - Next valid instruction 0x140@0x40.
  - FIFO contents before the redirect are flushed.
- Redirect in the same cycle as imem_rvalid:
  - Data not pushed.
  - imem_req addr=redirect_pc on the next cycle.
- imem_ready low 3 cycles in REQ:
  - imem_req and addr held constant.
  - fetch_pc does not advance until acceptance.
- Reset asserted while in WAIT, then imem_rvalid pulsed:
  - All outputs at reset values.
  - Stale response ignored.
  - Fetch restarts at RESET_PC.
